// File: rtl/bus_wr_capture.sv
// bus_wr_capture: synchronises the async CPU bus, qualifies M2 cycles and queues CPU writes as {addr,data}.
// Optional glitch filter on short M2 high phases: define MAP_M2_FILTER_EN (threshold M2_MIN_HI).
module bus_wr_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DLY  = 4,
  parameter int M2_MIN_HI   = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        map_rst,
  input  logic        m2,
  input  logic        cpu_ce,
  input  logic        cpu_rw,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_dat,
  output logic [4:0]  wr_level,
  output logic        ovf
);
  localparam int BW = 25;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] m2_sync_q;
  logic [BW-1:0]          bus_sync_q [SYNC_STAGES];
  logic                   m2_s, m2_q;
  logic [BW-1:0]          bus_s;

  assign m2_s  = m2_sync_q[SYNC_STAGES-1];
  assign bus_s = bus_sync_q[SYNC_STAGES-1];

  // M2 chain resets high so a reset inside a high phase never looks like a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_sync_q <= '1;
      m2_q      <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) bus_sync_q[i] <= '0;
    end else begin
      m2_sync_q     <= {m2_sync_q[SYNC_STAGES-2:0], m2};
      m2_q          <= m2_s;
      bus_sync_q[0] <= {cpu_ce, cpu_rw, cpu_addr, cpu_dat};
      for (int i = 1; i < SYNC_STAGES; i++) bus_sync_q[i] <= bus_sync_q[i-1];
    end
  end

  logic [7:0]  hi_cnt_q;
  logic        snap_vld_q, snap_ce_q, snap_rw_q;
  logic [14:0] snap_addr_q;
  logic [7:0]  snap_dat_q;
  logic        rise, fall, filt_ok, push;

  assign rise = m2_s & ~m2_q;
  assign fall = ~m2_s & m2_q;

`ifdef MAP_M2_FILTER_EN
  assign filt_ok = (hi_cnt_q >= 8'(M2_MIN_HI));
`else
  assign filt_ok = 1'b1;
  logic [7:0] unused_min_hi;
  assign unused_min_hi = 8'(M2_MIN_HI);
`endif

  assign push = fall & snap_vld_q & ~snap_rw_q & filt_ok;

  // A zero count means "no rise seen yet": counting only starts from a real rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_q    <= '0;
      snap_vld_q  <= 1'b0;
      snap_ce_q   <= 1'b0;
      snap_rw_q   <= 1'b0;
      snap_addr_q <= '0;
      snap_dat_q  <= '0;
    end else if (map_rst) begin
      hi_cnt_q   <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      if (!m2_s)                                    hi_cnt_q <= '0;
      else if (rise)                                hi_cnt_q <= 8'd1;
      else if (hi_cnt_q != 8'd0 && hi_cnt_q != 8'hFF) hi_cnt_q <= hi_cnt_q + 8'd1;

      if (rise) begin
        snap_vld_q <= 1'b0;
      end else if (m2_s && hi_cnt_q == 8'(SAMPLE_DLY)) begin
        snap_vld_q  <= 1'b1;
        snap_ce_q   <= bus_s[24];
        snap_rw_q   <= bus_s[23];
        snap_addr_q <= bus_s[22:8];
        snap_dat_q  <= bus_s[7:0];
      end else if (fall && !filt_ok) begin
        snap_vld_q <= 1'b0;
      end
    end
  end

  logic [23:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wcnt_q, rcnt_q, rnext, level;
  logic [23:0] head_q, push_dat;
  logic        empty, full, pop, push_ok;

  assign level    = wcnt_q - rcnt_q;
  assign empty    = (level == '0);
  assign full     = (level == DEPTH_C);
  assign pop      = wr_valid & wr_ready;
  assign push_ok  = push & (~full | pop);
  assign push_dat = {~snap_ce_q, snap_addr_q, snap_dat_q};
  assign rnext    = pop ? rcnt_q + 1'b1 : rcnt_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wcnt_q[AW-1:0]] <= push_dat;
  end

  // Registered head: follows the queue front, holds the last value once the queue drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      ovf    <= 1'b0;
      head_q <= '0;
    end else if (map_rst) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      ovf    <= 1'b0;
      head_q <= '0;
    end else begin
      if (push_ok) wcnt_q <= wcnt_q + 1'b1;
      rcnt_q <= rnext;
      if (push && full && !pop) ovf <= 1'b1;
      if ((pop || empty) && (rnext != wcnt_q || push_ok))
        head_q <= (rnext == wcnt_q) ? push_dat : mem_q[rnext[AW-1:0]];
    end
  end

  assign wr_valid = ~empty;
  assign wr_addr  = head_q[23:8];
  assign wr_dat   = head_q[7:0];
  assign wr_level = 5'(level);

endmodule

// File: tb/tb_bus_wr_capture.sv
// Testbench for bus_wr_capture: directed vector table, multi-cycle corner sequences, random writes vs. queue model.
module tb_bus_wr_capture;
  localparam int SAMPLE_DLY = 4;
  localparam int M2_MIN_HI  = 6;
`ifdef MAP_M2_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, map_rst = 1'b0, m2 = 1'b0;
  logic        cpu_ce = 1'b1, cpu_rw = 1'b1, wr_ready = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_dat = '0;
  logic        wr_valid, ovf;
  logic [15:0] wr_addr;
  logic [7:0]  wr_dat;
  logic [4:0]  wr_level;

  int n_chk = 0, n_pass = 0;
  bit mon_en = 1'b0, rnd_en = 1'b0;
  logic [23:0] exp_q[$];

  always #10 clk = ~clk;

  bus_wr_capture dut (
    .clk(clk), .rst_n(rst_n), .map_rst(map_rst), .m2(m2),
    .cpu_ce(cpu_ce), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .wr_level(wr_level), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock: observe the head at the falling edge, then drive just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (mon_en && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", {8'h0, wr_addr, wr_dat}, 32'hFFFFFFFF);
      else check("pop_data", {8'h0, wr_addr, wr_dat}, {8'h0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
    if (rnd_en) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic m2_cycle(input int hi, input logic ce, input logic rw,
                          input logic [14:0] a, input logic [7:0] d, input int lo);
    cpu_ce = ce; cpu_rw = rw; cpu_addr = a; cpu_dat = d; m2 = 1'b1;
    repeat (hi) step();
    m2 = 1'b0;
    repeat (lo) step();
  endtask

  function automatic bit qualifies(input int hi, input logic rw);
    return !rw && hi > SAMPLE_DLY && (!FILT || hi >= M2_MIN_HI);
  endfunction

  typedef struct {
    int          hi;
    logic        ce;
    logic        rw;
    logic [14:0] a;
    logic [7:0]  d;
    int          exp_n;
    logic [15:0] ea;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int lat;
    tbl[0] = '{16, 1'b0, 1'b0, 15'h0005, 8'h3C, 1, 16'h8005};
    tbl[1] = '{16, 1'b0, 1'b1, 15'h0005, 8'h99, 0, 16'h0000};
    tbl[2] = '{16, 1'b1, 1'b0, 15'h6000, 8'h11, 1, 16'h6000};
    tbl[3] = '{5,  1'b0, 1'b0, 15'h1234, 8'h5A, FILT ? 0 : 1, 16'h9234};
    tbl[4] = '{3,  1'b0, 1'b0, 15'h2222, 8'h22, 0, 16'h0000};
    tbl[5] = '{6,  1'b0, 1'b0, 15'h7FFF, 8'hFF, 1, 16'hFFFF};
    tbl[6] = '{16, 1'b1, 1'b0, 15'h0000, 8'h80, 1, 16'h0000};

    repeat (3) step();
    check("rst_valid", 32'(wr_valid), 0);
    rst_n = 1'b1;
    repeat (4) step();
    check("rst_level", 32'(wr_level), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_head", {8'h0, wr_addr, wr_dat}, 0);

    // Directed table: one M2 cycle per row, then a single pop.
    foreach (tbl[i]) begin
      m2_cycle(tbl[i].hi, tbl[i].ce, tbl[i].rw, tbl[i].a, tbl[i].d, 12);
      check($sformatf("tbl%0d_level", i), 32'(wr_level), 32'(tbl[i].exp_n));
      if (tbl[i].exp_n != 0) begin
        check($sformatf("tbl%0d_addr", i), 32'(wr_addr), 32'(tbl[i].ea));
        check($sformatf("tbl%0d_dat", i), 32'(wr_dat), 32'(tbl[i].d));
      end
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      check($sformatf("tbl%0d_drain", i), 32'(wr_level), 0);
      if (tbl[i].exp_n != 0) check($sformatf("tbl%0d_hold", i), 32'(wr_addr), 32'(tbl[i].ea));
    end

    // Pin-to-valid latency from the M2 pin fall.
    cpu_ce = 1'b0; cpu_rw = 1'b0; cpu_addr = 15'h0005; cpu_dat = 8'h3C; m2 = 1'b1;
    repeat (16) step();
    m2 = 1'b0;
    lat = 99;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (wr_valid && lat == 99) lat = k;
    end
    check("latency", 32'(lat), 3);
    check("lat_addr", 32'(wr_addr), 32'h8005);
    wr_ready = 1'b1; step(); wr_ready = 1'b0;
    check("lat_drain", 32'(wr_level), 0);
    repeat (4) step();

    // Overflow: five writes, nothing consumed.
    for (int i = 0; i < 5; i++) m2_cycle(16, 1'b0, 1'b0, 15'(i), 8'(8'hA0 + i), 12);
    check("ovf_level", 32'(wr_level), 4);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_head", {8'h0, wr_addr, wr_dat}, 32'h8000A0);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), {8'h0, wr_addr, wr_dat}, {8'h0, 16'h8000 + 16'(i), 8'(8'hA0 + i)});
      step();
    end
    wr_ready = 1'b0;
    check("ovf_empty", 32'(wr_level), 0);
    check("ovf_sticky", 32'(ovf), 1);
    map_rst = 1'b1; step(); map_rst = 1'b0;
    check("maprst_ovf", 32'(ovf), 0);
    check("maprst_head", {8'h0, wr_addr, wr_dat}, 0);

    // Full queue: push and pop on the same clock.
    for (int i = 0; i < 4; i++) m2_cycle(16, 1'b0, 1'b0, 15'(16 + i), 8'(8'hB0 + i), 12);
    check("full_level", 32'(wr_level), 4);
    cpu_addr = 15'h0014; cpu_dat = 8'hB4; m2 = 1'b1;
    repeat (16) step();
    m2 = 1'b0;
    step(); step();
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    check("pp_level", 32'(wr_level), 4);
    repeat (10) step();
    check("pp_ovf", 32'(ovf), 0);
    wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("pp_order%0d", i), {8'h0, wr_addr, wr_dat}, {8'h0, 16'h8010 + 16'(i), 8'(8'hB0 + i)});
      step();
    end
    wr_ready = 1'b0;
    check("pp_empty", 32'(wr_level), 0);

    // Async reset inside the high phase of a write.
    m2_cycle(16, 1'b0, 1'b0, 15'h0100, 8'h42, 12);
    check("arst_pre", 32'(wr_level), 1);
    cpu_addr = 15'h0101; cpu_dat = 8'h43; m2 = 1'b1;
    repeat (8) step();
    #2 rst_n = 1'b0;
    #2 check("arst_valid", 32'(wr_valid), 0);
    check("arst_level", 32'(wr_level), 0);
    #2 rst_n = 1'b1;
    repeat (8) step();
    m2 = 1'b0;
    repeat (12) step();
    check("arst_noevent", 32'(wr_level), 0);
    m2_cycle(16, 1'b0, 1'b0, 15'h0200, 8'h77, 12);
    check("arst_next", {8'h0, wr_addr, wr_dat}, 32'h820077);
    wr_ready = 1'b1; step(); wr_ready = 1'b0;

    // Random cycles against the queue model; consumer ready toggles randomly.
    mon_en = 1'b1;
    rnd_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int hi_opts[6] = '{2, 3, 5, 6, 8, 16};
      int hi = hi_opts[$urandom_range(0, 5)];
      logic ce = 1'($urandom_range(0, 1));
      logic rw = 1'($urandom_range(0, 2) == 0);
      logic [14:0] a = 15'($urandom);
      logic [7:0]  d = 8'($urandom);
      if (qualifies(hi, rw)) exp_q.push_back({~ce, a, d});
      m2_cycle(hi, ce, rw, a, d, $urandom_range(8, 14));
    end
    rnd_en = 1'b0;
    wr_ready = 1'b1;
    repeat (12) step();
    mon_en = 1'b0;
    check("rnd_model_empty", 32'(exp_q.size()), 0);
    check("rnd_level", 32'(wr_level), 0);
    check("rnd_ovf", 32'(ovf), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
